// File: rtl/ctrl_stream_arbiter.sv
// rtl/ctrl_stream_arbiter.sv - two-input packet-level round-robin stream arbiter
// Optional packet statistics: define CTRL_STREAM_ARBITER_STATS_EN.
module ctrl_stream_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
`ifdef CTRL_STREAM_ARBITER_STATS_EN
    parameter int CNT_WIDTH  = 32,
`endif
    parameter int USER_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_ap_rst,

    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_tkeep,
    input  logic [ID_WIDTH-1:0]   s0_tid,
    input  logic [DEST_WIDTH-1:0] s0_tdest,
    input  logic [USER_WIDTH-1:0] s0_tuser,
    input  logic                  s0_tlast,

    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_tkeep,
    input  logic [ID_WIDTH-1:0]   s1_tid,
    input  logic [DEST_WIDTH-1:0] s1_tdest,
    input  logic [USER_WIDTH-1:0] s1_tuser,
    input  logic                  s1_tlast,

    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic [ID_WIDTH-1:0]   m_tid,
    output logic [DEST_WIDTH-1:0] m_tdest,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic                  m_tlast,

    output logic [1:0]            o_grant
`ifdef CTRL_STREAM_ARBITER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  o_pkt_cnt1
`endif
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GRANT0 = 2'b01;
    localparam logic [1:0] GRANT1 = 2'b10;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       last_grant;
    logic       done0;
    logic       done1;

    assign done0 = (state == GRANT0) && s0_tvalid && m_tready && s0_tlast;
    assign done1 = (state == GRANT1) && s1_tvalid && m_tready && s1_tlast;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (s0_tvalid && (!s1_tvalid || last_grant))
                    next_state = GRANT0;
                else if (s1_tvalid)
                    next_state = GRANT1;
            end
            GRANT0:  if (done0) next_state = IDLE;
            GRANT1:  if (done1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT0)
                last_grant <= 1'b0;
            else if (state == IDLE && next_state == GRANT1)
                last_grant <= 1'b1;
        end
    end

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    always_comb begin
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tid     = '0;
        m_tdest   = '0;
        m_tuser   = '0;
        m_tlast   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state)
            GRANT0: begin
                m_tvalid  = s0_tvalid;
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tid     = s0_tid;
                m_tdest   = s0_tdest;
                m_tuser   = s0_tuser;
                m_tlast   = s0_tlast;
                s0_tready = m_tready;
            end
            GRANT1: begin
                m_tvalid  = s1_tvalid;
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tid     = s1_tid;
                m_tdest   = s1_tdest;
                m_tuser   = s1_tuser;
                m_tlast   = s1_tlast;
                s1_tready = m_tready;
            end
            default: ;
        endcase
    end

    assign o_grant = state;

`ifdef CTRL_STREAM_ARBITER_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            o_pkt_cnt0 <= '0;
            o_pkt_cnt1 <= '0;
        end else begin
            if (done0 && o_pkt_cnt0 != '1)
                o_pkt_cnt0 <= o_pkt_cnt0 + CNT_ONE;
            if (done1 && o_pkt_cnt1 != '1)
                o_pkt_cnt1 <= o_pkt_cnt1 + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_stream_arbiter.sv
// tb/tb_ctrl_stream_arbiter.sv - directed self-checking bench for ctrl_stream_arbiter
// Statistics checks are built when CTRL_STREAM_ARBITER_STATS_EN is defined.
module tb_ctrl_stream_arbiter;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 16;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s0_tvalid, s0_tready, s0_tlast;
    logic [DW-1:0] s0_tdata;
    logic [KW-1:0] s0_tkeep;
    logic [IW-1:0] s0_tid;
    logic [DSW-1:0] s0_tdest;
    logic [UW-1:0] s0_tuser;
    logic          s1_tvalid, s1_tready, s1_tlast;
    logic [DW-1:0] s1_tdata;
    logic [KW-1:0] s1_tkeep;
    logic [IW-1:0] s1_tid;
    logic [DSW-1:0] s1_tdest;
    logic [UW-1:0] s1_tuser;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [IW-1:0] m_tid;
    logic [DSW-1:0] m_tdest;
    logic [UW-1:0] m_tuser;
    logic [1:0]    o_grant;
`ifdef CTRL_STREAM_ARBITER_STATS_EN
    logic [CW-1:0] o_pkt_cnt0, o_pkt_cnt1;
`endif

    ctrl_stream_arbiter #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
`ifdef CTRL_STREAM_ARBITER_STATS_EN
        .CNT_WIDTH(CW),
`endif
        .USER_WIDTH(UW)
    ) dut (
        .i_clk(clk), .i_ap_rst(rst),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep),
        .s0_tid(s0_tid), .s0_tdest(s0_tdest), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep),
        .s1_tid(s1_tid), .s1_tdest(s1_tdest), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .o_grant(o_grant)
`ifdef CTRL_STREAM_ARBITER_STATS_EN
        ,
        .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
`endif
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [DW-1:0] d, input logic l);
        s0_tvalid = v;
        s0_tdata  = d;
        s0_tlast  = l;
    endtask

    task automatic drv1(input logic v, input logic [DW-1:0] d, input logic l);
        s1_tvalid = v;
        s1_tdata  = d;
        s1_tlast  = l;
    endtask

    logic [1:0] exp_g [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    initial begin
        rst = 1'b1;
        m_tready = 1'b0;
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        s0_tkeep = 8'hFF; s0_tid = 8'h5A; s0_tdest = 8'hCD; s0_tuser = 16'h1234;
        s1_tkeep = 8'h0F; s1_tid = 8'hA5; s1_tdest = 8'h11; s1_tuser = 16'h4321;
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s0_tready", s0_tready, 0);
        check("rst_s1_tready", s1_tready, 0);
        check("rst_grant", o_grant, 0);
        check("rst_m_tdata", m_tdata, 0);
`ifdef CTRL_STREAM_ARBITER_STATS_EN
        check("rst_cnt0", o_pkt_cnt0, 0);
        check("rst_cnt1", o_pkt_cnt1, 0);
`endif
        tick();
        rst = 1'b0;

        // Three-beat packet on port 0 only
        drv0(1'b1, 64'hABCD_0000_0000_0001, 1'b0);
        m_tready = 1'b1;
        #1;
        check("t1_idle_grant", o_grant, 2'b00);
        check("t1_idle_mvalid", m_tvalid, 0);
        tick(); #1;
        check("t1_grant", o_grant, 2'b01);
        check("t1_b1_data", m_tdata, 64'hABCD_0000_0000_0001);
        check("t1_b1_dest", m_tdest, 8'hCD);
        check("t1_b1_keep", m_tkeep, 8'hFF);
        check("t1_b1_id", m_tid, 8'h5A);
        check("t1_b1_user", m_tuser, 16'h1234);
        check("t1_s0_tready", s0_tready, 1);
        check("t1_s1_tready", s1_tready, 0);
        tick();
        drv0(1'b1, 64'hABCD_0000_0000_0002, 1'b0);
        #1;
        check("t1_b2_data", m_tdata, 64'hABCD_0000_0000_0002);
        check("t1_b2_last", m_tlast, 0);
        tick();
        drv0(1'b1, 64'hABCD_0000_0000_0003, 1'b1);
        #1;
        check("t1_b3_data", m_tdata, 64'hABCD_0000_0000_0003);
        check("t1_b3_last", m_tlast, 1);
        check("t1_b3_s1_tready", s1_tready, 0);
        tick();
        drv0(1'b0, '0, 1'b0);
        #1;
        check("t1_after_idle", o_grant, 2'b00);

        // Both ports hold single-beat packets: alternating grants with a bubble
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv0(1'b1, 64'h0000_0000_0000_00A0, 1'b1);
        drv1(1'b1, 64'h0000_0000_0000_00B1, 1'b1);
        #1;
        check("t2_idle", o_grant, 2'b00);
        for (int i = 0; i < 7; i++) begin
            tick(); #1;
            check($sformatf("t2_grant_%0d", i), o_grant, exp_g[i]);
            check($sformatf("t2_mvalid_%0d", i), m_tvalid, exp_g[i] != 2'b00);
            if (exp_g[i] == 2'b01) check($sformatf("t2_data_%0d", i), m_tdata, 64'hA0);
            if (exp_g[i] == 2'b10) check($sformatf("t2_data_%0d", i), m_tdata, 64'hB1);
        end
        tick();
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);
        #1;
        check("t2_end_idle", o_grant, 2'b00);

        // Port 0 stalls mid-packet while port 1 waits
        drv0(1'b1, 64'h0000_0000_0000_0B00, 1'b0);
        drv1(1'b1, 64'h0000_0000_0000_0C11, 1'b1);
        tick(); #1;
        check("t3_grant", o_grant, 2'b01);
        check("t3_b0", m_tdata, 64'hB00);
        tick();
        drv0(1'b1, 64'h0000_0000_0000_0B01, 1'b0);
        #1;
        check("t3_b1", m_tdata, 64'hB01);
        tick();
        drv0(1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t3_gap_grant_%0d", i), o_grant, 2'b01);
            check($sformatf("t3_gap_mvalid_%0d", i), m_tvalid, 0);
            check($sformatf("t3_gap_s1rdy_%0d", i), s1_tready, 0);
            tick();
        end
        drv0(1'b1, 64'h0000_0000_0000_0B02, 1'b0);
        #1;
        check("t3_b2", m_tdata, 64'hB02);
        check("t3_b2_grant", o_grant, 2'b01);
        tick();
        drv0(1'b1, 64'h0000_0000_0000_0B03, 1'b1);
        #1;
        check("t3_b3", m_tdata, 64'hB03);
        check("t3_b3_s1rdy", s1_tready, 0);
        tick();
        drv0(1'b0, '0, 1'b0);
        #1;
        check("t3_bubble", o_grant, 2'b00);
        check("t3_bubble_s1rdy", s1_tready, 0);
        tick(); #1;
        check("t3_p1_grant", o_grant, 2'b10);
        check("t3_p1_data", m_tdata, 64'hC11);
        check("t3_p1_s1rdy", s1_tready, 1);
        tick();
        drv1(1'b0, '0, 1'b0);
        #1;
        check("t3_end_idle", o_grant, 2'b00);

        // Port 1 two-beat packet with m_tready toggling
        drv1(1'b1, 64'h0000_0000_0000_0CC0, 1'b0);
        tick(); #1;
        check("t4_grant", o_grant, 2'b10);
        check("t4_b0", m_tdata, 64'hCC0);
        check("t4_b0_rdy", s1_tready, 1);
        tick();
        drv1(1'b1, 64'h0000_0000_0000_0CC1, 1'b1);
        m_tready = 1'b0;
        #1;
        check("t4_b1_stall_data", m_tdata, 64'hCC1);
        check("t4_b1_stall_rdy", s1_tready, 0);
        check("t4_b1_stall_valid", m_tvalid, 1);
        tick();
        m_tready = 1'b1;
        #1;
        check("t4_b1_hold_data", m_tdata, 64'hCC1);
        check("t4_b1_hold_grant", o_grant, 2'b10);
        check("t4_b1_rdy", s1_tready, 1);
        tick();
        m_tready = 1'b0;
        drv1(1'b0, '0, 1'b0);
        #1;
        check("t4_end_idle", o_grant, 2'b00);

        // Reset mid-packet on port 0
        m_tready = 1'b1;
        drv0(1'b1, 64'h0000_0000_0000_0E00, 1'b0);
        tick(); #1;
        check("t5_grant", o_grant, 2'b01);
        tick();
        drv0(1'b1, 64'h0000_0000_0000_0E01, 1'b1);
        drv1(1'b1, 64'h0000_0000_0000_0F11, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_mvalid", m_tvalid, 0);
        check("t5_rst_s0rdy", s0_tready, 0);
        check("t5_rst_s1rdy", s1_tready, 0);
        check("t5_rst_grant", o_grant, 2'b00);
        tick();
        rst = 1'b0;
        tick(); #1;
        check("t5_post_grant", o_grant, 2'b01);
        check("t5_post_data", m_tdata, 64'hE01);
        tick();
        drv0(1'b0, '0, 1'b0);
        #1;
        check("t5_bubble", o_grant, 2'b00);
        tick(); #1;
        check("t5_p1_grant", o_grant, 2'b10);
        tick();
        drv1(1'b0, '0, 1'b0);
        #1;
        check("t5_end_idle", o_grant, 2'b00);

`ifdef CTRL_STREAM_ARBITER_STATS_EN
        // Packet counters with saturation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_cnt0_zero", o_pkt_cnt0, 0);
        for (int i = 0; i < 17; i++) begin
            drv0(1'b1, 64'(i), 1'b1);
            tick();
            tick();
            drv0(1'b0, '0, 1'b0);
            if (i == 14) begin
                #1;
                check("t6_cnt0_15", o_pkt_cnt0, 15);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drv1(1'b1, 64'(i), 1'b1);
            tick();
            tick();
            drv1(1'b0, '0, 1'b0);
        end
        #1;
        check("t6_cnt0_sat", o_pkt_cnt0, 15);
        check("t6_cnt1", o_pkt_cnt1, 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
